// File: rtl/sync_debounce.sv
// Purpose: synchronize a raw asynchronous input and debounce it into a clean level plus edge pulses.
// Latency: a settled input change reaches level_o STABLE_CYCLES+2 rising edges after it is first sampled.
// Backpressure: none; the block free-runs on every clock and never stalls its input.
module sync_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_i,
    output logic       level_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic [7:0] rise_cnt_o
);

    // Terminal count: a mismatch seen on this many consecutive cycles is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [7:0]       rise_cnt_q;
    logic [7:0]       rise_cnt_d;
    logic             accept;

    // Two-flop synchronizer; s1_q is the only flop that ever looks at d_i.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    // Stability qualification: count consecutive mismatches, accept on terminal count.
    always_comb begin
        accept     = 1'b0;
        cnt_d      = cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        rise_cnt_d = rise_cnt_q;
        if (s2_q == level_q) begin
            // Any agreement, however brief, restarts qualification from zero.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            accept  = 1'b1;
            cnt_d   = '0;
            level_d = s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept) begin
            // The new level and its pulse land on the same edge, so the pulse marks
            // exactly the first cycle in which level_o shows the accepted value.
            rise_d = s2_q;
            fall_d = ~s2_q;
            if (s2_q) begin
                rise_cnt_d = rise_cnt_q + 8'd1;
            end
        end
    end

    // Qualification state, level and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            rise_cnt_q <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign rise_cnt_o = rise_cnt_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: two instances (STABLE_CYCLES=4 and 1) on one input,
// compared every cycle against a window-based reference plus directed latency checks.
module tb_sync_debounce;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       d     = 1'b0;
    logic       l4, r4, f4, l1, r1, f1;
    logic [7:0] c4, c1;

    int errors = 0;
    int checks = 0;
    int rises4 = 0;
    int falls4 = 0;

    sync_debounce #(.STABLE_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .d_i(d),
        .level_o(l4), .rise_o(r4), .fall_o(f4), .rise_cnt_o(c4)
    );

    sync_debounce #(.STABLE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .d_i(d),
        .level_o(l1), .rise_o(r1), .fall_o(f1), .rise_cnt_o(c1)
    );

    always #5 clk = ~clk;

    // Reference: a new value is accepted when the last N synchronized samples
    // taken since the previous acceptance all differ from the current level.
    bit        p1 = 1'b0;
    bit        p2 = 1'b0;
    bit [15:0] hist [2];
    int        hn   [2];
    bit        ml   [2];
    bit        mr   [2];
    bit        mf   [2];
    bit [7:0]  mc   [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            hist[i] = '0; hn[i] = 0; ml[i] = 0; mr[i] = 0; mf[i] = 0; mc[i] = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        bit s2pre;
        bit all_diff;
        int n;
        if (!reset) begin
            p1 = 1'b0;
            p2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                hist[i] = '0; hn[i] = 0; ml[i] = 0; mr[i] = 0; mf[i] = 0; mc[i] = 0;
            end
        end else begin
            s2pre = p2;
            p2    = p1;
            p1    = d;
            for (int i = 0; i < 2; i++) begin
                n       = (i == 0) ? 4 : 1;
                mr[i]   = 1'b0;
                mf[i]   = 1'b0;
                hist[i] = {hist[i][14:0], s2pre};
                if (hn[i] < 16) hn[i] = hn[i] + 1;
                all_diff = (hn[i] >= n);
                for (int j = 0; j < n; j++) begin
                    if (hist[i][j] == ml[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    ml[i] = ~ml[i];
                    mr[i] = ml[i];
                    mf[i] = ~ml[i];
                    if (ml[i]) mc[i] = mc[i] + 8'd1;
                    hn[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("lvl4", {7'd0, l4}, {7'd0, ml[0]});
        chk("rise4", {7'd0, r4}, {7'd0, mr[0]});
        chk("fall4", {7'd0, f4}, {7'd0, mf[0]});
        chk("cnt4", c4, mc[0]);
        chk("lvl1", {7'd0, l1}, {7'd0, ml[1]});
        chk("rise1", {7'd0, r1}, {7'd0, mr[1]});
        chk("fall1", {7'd0, f1}, {7'd0, mf[1]});
        chk("cnt1", c1, mc[1]);
        chk("excl4", {7'd0, r4 & f4}, 8'd0);
        chk("excl1", {7'd0, r1 & f1}, 8'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_lvl4"}, {7'd0, l4}, 8'd0);
        chk({tag, "_rise4"}, {7'd0, r4}, 8'd0);
        chk({tag, "_fall4"}, {7'd0, f4}, 8'd0);
        chk({tag, "_cnt4"}, c4, 8'd0);
        chk({tag, "_lvl1"}, {7'd0, l1}, 8'd0);
        chk({tag, "_cnt1"}, c1, 8'd0);
    endtask

    // One clock: check at the falling edge, then drive the next input value.
    task automatic cyc(input logic dv);
        @(negedge clk);
        check_model();
        if (r4) rises4++;
        if (f4) falls4++;
        d = dv;
    endtask

    task automatic hold(input logic dv, input int n);
        for (int k = 0; k < n; k++) cyc(dv);
    endtask

    int r_before, f_before;
    logic [7:0] c_before;

    initial begin
        // Reset state, with clocks running while reset is held low.
        #12;
        check_zero("rst");
        @(posedge clk); #1;
        check_zero("rst_clk");
        @(negedge clk);
        reset = 1'b1;
        hold(1'b0, 5);

        // Clean 0->1: level after edge 6 (N=4) and edge 3 (N=1), single pulse.
        @(negedge clk);
        d = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            chk("lat_lvl4", {7'd0, l4}, {7'd0, (e >= 6)});
            chk("lat_rise4", {7'd0, r4}, {7'd0, (e == 6)});
            chk("lat_lvl1", {7'd0, l1}, {7'd0, (e >= 3)});
            chk("lat_rise1", {7'd0, r1}, {7'd0, (e == 3)});
        end
        chk("lat_cnt4", c4, 8'd1);
        chk("lat_cnt1", c1, 8'd1);
        hold(1'b1, 3);
        hold(1'b0, 10);

        // Three-cycle pulse is rejected by N=4.
        r_before = rises4;
        c_before = c4;
        hold(1'b1, 3);
        hold(1'b0, 10);
        chk("glitch_rises4", 8'(rises4 - r_before), 8'd0);
        chk("glitch_cnt4", c4, c_before);

        // Bounce 1,0,1,1,0,1,1,1,1: only the final run is accepted.
        r_before = rises4;
        cyc(1); cyc(0); cyc(1); cyc(1); cyc(0);
        hold(1'b1, 10);
        chk("bounce_rises4", 8'(rises4 - r_before), 8'd1);
        hold(1'b0, 10);

        // Random bouncing with hold lengths from 1 to 8 cycles.
        for (int k = 0; k < 300; k++) begin
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        end
        hold(1'b0, 10);

        // 256 clean rises: counter wraps, fall count matches rise count.
        r_before = rises4;
        f_before = falls4;
        c_before = c4;
        for (int k = 0; k < 256; k++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        chk("wrap_cnt4", c4, c_before);
        chk("wrap_rises4", 8'((rises4 - r_before) >> 1), 8'd128);
        chk("wrap_falls_eq", 8'(falls4 - f_before), 8'(rises4 - r_before));

        // Reset mid-qualification, then d held high after release.
        hold(1'b1, 4);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_zero("async");
        @(posedge clk); #1;
        check_zero("async_clk");
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            chk("rel_lvl4", {7'd0, l4}, {7'd0, (e >= 6)});
            chk("rel_rise4", {7'd0, r4}, {7'd0, (e == 6)});
            chk("rel_cnt4", c4, {7'd0, (e >= 6)});
        end
        hold(1'b1, 3);
        hold(1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
